// File: rtl/lead_one_bist_if.sv
// Stimulus/response bus between the leading-one BIST controller and its environment.
// The BIST is the slave side: it takes start and the encoder result, and reports results.
interface lead_one_bist_if #(
   parameter int WIDTH = 10,
   parameter int OW    = 4
);
   logic             start;
   logic [WIDTH-1:0] stim;
   logic [OW-1:0]    dut_out;
   logic             dut_zero;
   logic             busy;
   logic             done;
   logic [WIDTH:0]   pass_cnt;
   logic [WIDTH:0]   fail_cnt;
   logic             alarm;
   logic [WIDTH-1:0] first_fail_stim;

   modport master (
      output start, dut_out, dut_zero,
      input  stim, busy, done, pass_cnt, fail_cnt, alarm, first_fail_stim
   );

   modport slave (
      input  start, dut_out, dut_zero,
      output stim, busy, done, pass_cnt, fail_cnt, alarm, first_fail_stim
   );
endinterface

// File: rtl/lead_one_bist.sv
// Exhaustive self-test for an external leading-one encoder: sweeps every stimulus value,
// compares the encoder result against an internal reference and counts passes/fails.
module lead_one_bist #(
   parameter int WIDTH = 10,
   parameter int OW    = 4,
   parameter int LAT   = 1
) (
   input  logic          clk,
   input  logic          rst,
   lead_one_bist_if.slave bus
);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   localparam logic [WIDTH-1:0] STIM_MAX = '1;

   state_t           state;
   logic [2:0]       drain_cnt;
   logic [WIDTH-1:0] stim;
   logic             busy;
   logic             done;
   logic [WIDTH:0]   pass_cnt;
   logic [WIDTH:0]   fail_cnt;
   logic             alarm;
   logic [WIDTH-1:0] first_fail_stim;

   function automatic logic [OW-1:0] lead_one(input logic [WIDTH-1:0] v);
      logic [OW-1:0] idx;
      idx = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (v[i]) idx = OW'(i);
      end
      return idx;
   endfunction

   // Stage p0: reference result for the stimulus currently on the bus
   logic             vld_p0;
   logic             zero_p0;
   logic [OW-1:0]    val_p0;
   logic [WIDTH-1:0] stim_p0;

   assign vld_p0  = (state == RUN);
   assign zero_p0 = (stim == '0);
   assign val_p0  = lead_one(stim);
   assign stim_p0 = stim;

   // Stage p1: reference delayed to line up with the encoder's latency
   logic             vld_p1;
   logic             zero_p1;
   logic [OW-1:0]    val_p1;
   logic [WIDTH-1:0] stim_p1;

   generate
      if (LAT == 0) begin : g_nodly
         assign vld_p1  = vld_p0;
         assign zero_p1 = zero_p0;
         assign val_p1  = val_p0;
         assign stim_p1 = stim_p0;
      end else begin : g_dly
         logic [LAT-1:0]   vld_dl;
         logic [LAT-1:0]   zero_dl;
         logic [OW-1:0]    val_dl  [LAT];
         logic [WIDTH-1:0] stim_dl [LAT];

         always_ff @(posedge clk) begin
            if (rst) begin
               vld_dl <= '0;
            end else begin
               vld_dl[0] <= vld_p0;
               for (int i = 1; i < LAT; i++) vld_dl[i] <= vld_dl[i-1];
            end
         end

         always_ff @(posedge clk) begin
            zero_dl[0] <= zero_p0;
            val_dl[0]  <= val_p0;
            stim_dl[0] <= stim_p0;
            for (int i = 1; i < LAT; i++) begin
               zero_dl[i] <= zero_dl[i-1];
               val_dl[i]  <= val_dl[i-1];
               stim_dl[i] <= stim_dl[i-1];
            end
         end

         assign vld_p1  = vld_dl[LAT-1];
         assign zero_p1 = zero_dl[LAT-1];
         assign val_p1  = val_dl[LAT-1];
         assign stim_p1 = stim_dl[LAT-1];
      end
   endgenerate

   // Unknown encoder outputs never count as a match
   logic known_p1;
   logic match_p1;

   assign known_p1 = !$isunknown({bus.dut_out, bus.dut_zero});
   assign match_p1 = known_p1 &&
                     (zero_p1 ? bus.dut_zero : (!bus.dut_zero && (bus.dut_out == val_p1)));

   always_ff @(posedge clk) begin
      if (rst) begin
         state           <= IDLE;
         drain_cnt       <= '0;
         stim            <= '0;
         busy            <= 1'b0;
         done            <= 1'b0;
         pass_cnt        <= '0;
         fail_cnt        <= '0;
         alarm           <= 1'b0;
         first_fail_stim <= '0;
      end else begin
         done <= 1'b0;

         if (vld_p1) begin
            if (match_p1) begin
               pass_cnt <= pass_cnt + 1'b1;
            end else begin
               fail_cnt <= fail_cnt + 1'b1;
               if (!alarm) begin
                  alarm           <= 1'b1;
                  first_fail_stim <= stim_p1;
               end
            end
         end

         case (state)
            IDLE: begin
               if (bus.start) begin
                  state           <= RUN;
                  busy            <= 1'b1;
                  stim            <= '0;
                  pass_cnt        <= '0;
                  fail_cnt        <= '0;
                  alarm           <= 1'b0;
                  first_fail_stim <= '0;
               end
            end
            RUN: begin
               if (stim == STIM_MAX) begin
                  if (LAT == 0) begin
                     state <= DONE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end else begin
                     state     <= DRAIN;
                     drain_cnt <= 3'(LAT - 1);
                  end
               end else begin
                  stim <= stim + 1'b1;
               end
            end
            DRAIN: begin
               if (drain_cnt == '0) begin
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end else begin
                  drain_cnt <= drain_cnt - 1'b1;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.stim            = stim;
   assign bus.busy            = busy;
   assign bus.done            = done;
   assign bus.pass_cnt        = pass_cnt;
   assign bus.fail_cnt        = fail_cnt;
   assign bus.alarm           = alarm;
   assign bus.first_fail_stim = first_fail_stim;

endmodule

// File: tb/tb_lead_one_bist.sv
// Bench for lead_one_bist: three controllers (LAT 1, 0, 3) each driving its own encoder
// model; sweep outcomes are queued as expectations and checked when done appears.
module tb_lead_one_bist;
   localparam int W  = 10;
   localparam int OW = 4;
   localparam int N  = 1 << W;

   typedef struct {
      int pass;
      int fail;
      bit alarm;
      int ffs;
      int dcyc;
   } exp_t;

   exp_t sb[$];

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   mode = 0;
   int   tests_run = 0;
   int   tests_failed = 0;

   always #5 clk = ~clk;

   lead_one_bist_if #(.WIDTH(W), .OW(OW)) bus0 ();
   lead_one_bist_if #(.WIDTH(W), .OW(OW)) bus1 ();
   lead_one_bist_if #(.WIDTH(W), .OW(OW)) bus2 ();

   lead_one_bist #(.WIDTH(W), .OW(OW), .LAT(1)) dut_l1 (.clk(clk), .rst(rst), .bus(bus0));
   lead_one_bist #(.WIDTH(W), .OW(OW), .LAT(0)) dut_l0 (.clk(clk), .rst(rst), .bus(bus1));
   lead_one_bist #(.WIDTH(W), .OW(OW), .LAT(3)) dut_l3 (.clk(clk), .rst(rst), .bus(bus2));

   function automatic logic [OW-1:0] ref_lo(input logic [W-1:0] v);
      for (int i = W - 1; i >= 0; i--) begin
         if (v[i]) return OW'(i);
      end
      return '0;
   endfunction

   // Encoder under test for LAT=1, with optional planted faults
   logic [OW-1:0] m0_out;
   logic          m0_zero;
   always_ff @(posedge clk) begin
      m0_out  <= (mode == 1 && bus0.stim[3:0] == 4'b1011) ? 4'hF : ref_lo(bus0.stim);
      m0_zero <= (mode == 2) ? 1'b0 : (bus0.stim == '0);
   end
   assign bus0.dut_out  = m0_out;
   assign bus0.dut_zero = m0_zero;

   assign bus1.dut_out  = ref_lo(bus1.stim);
   assign bus1.dut_zero = (bus1.stim == '0);

   logic [OW-1:0] m2_out  [3];
   logic          m2_zero [3];
   always_ff @(posedge clk) begin
      m2_out[0]  <= ref_lo(bus2.stim);
      m2_zero[0] <= (bus2.stim == '0);
      for (int i = 1; i < 3; i++) begin
         m2_out[i]  <= m2_out[i-1];
         m2_zero[i] <= m2_zero[i-1];
      end
   end
   assign bus2.dut_out  = m2_out[2];
   assign bus2.dut_zero = m2_zero[2];

   logic [2:0]   start_s = '0;
   logic [2:0]   busy_s, done_s, alarm_s;
   logic [W-1:0] stim_s [3];
   logic [W-1:0] ffs_s  [3];
   logic [W:0]   pass_s [3];
   logic [W:0]   fail_s [3];

   assign bus0.start = start_s[0];
   assign bus1.start = start_s[1];
   assign bus2.start = start_s[2];
   assign busy_s  = {bus2.busy, bus1.busy, bus0.busy};
   assign done_s  = {bus2.done, bus1.done, bus0.done};
   assign alarm_s = {bus2.alarm, bus1.alarm, bus0.alarm};
   assign stim_s[0] = bus0.stim;
   assign stim_s[1] = bus1.stim;
   assign stim_s[2] = bus2.stim;
   assign ffs_s[0]  = bus0.first_fail_stim;
   assign ffs_s[1]  = bus1.first_fail_stim;
   assign ffs_s[2]  = bus2.first_fail_stim;
   assign pass_s[0] = bus0.pass_cnt;
   assign pass_s[1] = bus1.pass_cnt;
   assign pass_s[2] = bus2.pass_cnt;
   assign fail_s[0] = bus0.fail_cnt;
   assign fail_s[1] = bus1.fail_cnt;
   assign fail_s[2] = bus2.fail_cnt;

   // Pulses start, follows the sweep cycle by cycle (cycle 1 = first cycle after the
   // start edge) and stays 4 cycles past done. extra adds start pulses at stim=100 and
   // in the done cycle. dcyc=0 means done never appeared within the budget.
   task automatic run_sweep(input int sel, input bit extra,
                            output int dcyc, output int ndone, output int stim_bad);
      int n;
      n = 0;
      dcyc = 0;
      ndone = 0;
      stim_bad = 0;
      @(negedge clk);
      start_s[sel] = 1'b1;
      forever begin
         @(negedge clk);
         n++;
         start_s[sel] = 1'b0;
         if (stim_s[sel] !== W'((n <= N) ? n - 1 : N - 1)) stim_bad++;
         if (extra && n == 101) start_s[sel] = 1'b1;
         if (done_s[sel] === 1'b1) begin
            ndone++;
            if (dcyc == 0) begin
               dcyc = n;
               if (extra) start_s[sel] = 1'b1;
            end
         end
         if (dcyc != 0 && n >= dcyc + 4) break;
         if (n > N + 40) break;
      end
      start_s[sel] = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      start_s = '0;
      repeat (3) @(negedge clk);
      tests_run++;
      if (stim_s[0] !== '0 || ffs_s[0] !== '0) begin
         tests_failed++;
         $display("FAIL reset_stim: stim=%0d ffs=%0d, want 0 0", stim_s[0], ffs_s[0]);
      end
      tests_run++;
      if ({busy_s[0], done_s[0], alarm_s[0]} !== 3'b000) begin
         tests_failed++;
         $display("FAIL reset_flags: busy/done/alarm=%b, want 000", {busy_s[0], done_s[0], alarm_s[0]});
      end
      tests_run++;
      if (pass_s[0] !== '0 || fail_s[0] !== '0) begin
         tests_failed++;
         $display("FAIL reset_counts: pass=%0d fail=%0d, want 0 0", pass_s[0], fail_s[0]);
      end
      rst = 1'b0;
   endtask

   task automatic test_sweep(input string name, input int sel, input int m, input int exp_pass,
                             input int exp_fail, input bit exp_alarm, input int exp_ffs, input int lat);
      exp_t e;
      int dcyc, ndone, stim_bad;
      mode = m;
      sb.push_back('{exp_pass, exp_fail, exp_alarm, exp_ffs, N + lat + 1});
      run_sweep(sel, 1'b0, dcyc, ndone, stim_bad);
      e = sb.pop_front();
      tests_run++;
      if (dcyc !== e.dcyc || ndone !== 1) begin
         tests_failed++;
         $display("FAIL %s_done: cycle=%0d count=%0d, want cycle=%0d count=1", name, dcyc, ndone, e.dcyc);
      end
      tests_run++;
      if (stim_bad !== 0) begin
         tests_failed++;
         $display("FAIL %s_stim_seq: %0d wrong stim cycles, want 0", name, stim_bad);
      end
      tests_run++;
      if (pass_s[sel] !== (W+1)'(e.pass) || fail_s[sel] !== (W+1)'(e.fail)) begin
         tests_failed++;
         $display("FAIL %s_counts: pass=%0d fail=%0d, want %0d %0d", name, pass_s[sel], fail_s[sel], e.pass, e.fail);
      end
      tests_run++;
      if (alarm_s[sel] !== e.alarm || ffs_s[sel] !== W'(e.ffs)) begin
         tests_failed++;
         $display("FAIL %s_alarm: alarm=%b ffs=%0d, want %b %0d", name, alarm_s[sel], ffs_s[sel], e.alarm, e.ffs);
      end
   endtask

   task automatic test_reset_mid_sweep();
      mode = 1;
      @(negedge clk);
      start_s[0] = 1'b1;
      @(negedge clk);
      start_s[0] = 1'b0;
      repeat (500) @(negedge clk);
      tests_run++;
      if (stim_s[0] !== W'(500) || busy_s[0] !== 1'b1 || fail_s[0] === '0) begin
         tests_failed++;
         $display("FAIL mid_precond: stim=%0d busy=%b fail=%0d, want 500 1 nonzero", stim_s[0], busy_s[0], fail_s[0]);
      end
      rst = 1'b1;
      @(negedge clk);
      tests_run++;
      if (stim_s[0] !== '0 || busy_s[0] !== 1'b0 || done_s[0] !== 1'b0 || pass_s[0] !== '0 ||
          fail_s[0] !== '0 || alarm_s[0] !== 1'b0 || ffs_s[0] !== '0) begin
         tests_failed++;
         $display("FAIL mid_reset: stim=%0d busy=%b done=%b pass=%0d fail=%0d alarm=%b ffs=%0d, want all 0",
                  stim_s[0], busy_s[0], done_s[0], pass_s[0], fail_s[0], alarm_s[0], ffs_s[0]);
      end
      rst = 1'b0;
      test_sweep("after_reset", 0, 0, N, 0, 1'b0, 0, 1);
   endtask

   task automatic test_ignored_start();
      exp_t e;
      int dcyc, ndone, stim_bad;
      mode = 0;
      sb.push_back('{N, 0, 1'b0, 0, N + 2});
      run_sweep(0, 1'b1, dcyc, ndone, stim_bad);
      e = sb.pop_front();
      tests_run++;
      if (dcyc !== e.dcyc || ndone !== 1) begin
         tests_failed++;
         $display("FAIL ign_done: cycle=%0d count=%0d, want cycle=%0d count=1", dcyc, ndone, e.dcyc);
      end
      tests_run++;
      if (stim_bad !== 0) begin
         tests_failed++;
         $display("FAIL ign_stim_seq: %0d wrong stim cycles, want 0", stim_bad);
      end
      tests_run++;
      if (pass_s[0] !== (W+1)'(e.pass) || fail_s[0] !== (W+1)'(e.fail) || alarm_s[0] !== e.alarm) begin
         tests_failed++;
         $display("FAIL ign_counts: pass=%0d fail=%0d alarm=%b, want %0d %0d %b",
                  pass_s[0], fail_s[0], alarm_s[0], e.pass, e.fail, e.alarm);
      end
      tests_run++;
      if (busy_s[0] !== 1'b0) begin
         tests_failed++;
         $display("FAIL ign_idle: busy=%b after sweep, want 0", busy_s[0]);
      end
   endtask

   task automatic test_rst_priority();
      @(negedge clk);
      rst = 1'b1;
      start_s[0] = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      start_s[0] = 1'b0;
      tests_run++;
      if (busy_s[0] !== 1'b0 || stim_s[0] !== '0 || pass_s[0] !== '0) begin
         tests_failed++;
         $display("FAIL rst_prio: busy=%b stim=%0d pass=%0d, want 0 0 0", busy_s[0], stim_s[0], pass_s[0]);
      end
      repeat (3) @(negedge clk);
      tests_run++;
      if (busy_s[0] !== 1'b0 || stim_s[0] !== '0) begin
         tests_failed++;
         $display("FAIL rst_prio_hold: busy=%b stim=%0d, want 0 0", busy_s[0], stim_s[0]);
      end
   endtask

   initial begin
      test_reset();
      test_sweep("ideal", 0, 0, N, 0, 1'b0, 0, 1);
      test_sweep("trigger", 0, 1, N - 64, 64, 1'b1, 11, 1);
      test_sweep("zero_flag", 0, 2, N - 1, 1, 1'b1, 0, 1);
      test_reset_mid_sweep();
      test_ignored_start();
      test_sweep("lat0", 1, 0, N, 0, 1'b0, 0, 0);
      test_sweep("lat3", 2, 0, N, 0, 1'b0, 0, 3);
      test_rst_priority();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule

// File: doc/lead_one_bist.md
LEAD_ONE_BIST -- requirements
Module: lead_one_bist

Interface
REQ-001: The block SHALL have parameter WIDTH, default 10, setting the stimulus width in bits, with a legal range of 2..16.
REQ-002: The block SHALL have parameter OW, default 4, setting the encoder output width, which SHALL satisfy 2^OW >= WIDTH.
REQ-003: The block SHALL have parameter LAT, default 1, setting the DUT latency in cycles from stim to dut_out/dut_zero, with a legal range of 0..7.
REQ-004: Port clk SHALL be an input of width 1: the single clock; all state updates on its rising edge.
REQ-005: Port rst SHALL be an input of width 1: reset, synchronous and active-high.
REQ-006: Port start SHALL be an input of width 1: a request to begin one full sweep.
REQ-007: Port stim SHALL be an output of width WIDTH: the stimulus driven to the external leading-one encoder under test.
REQ-008: Port dut_out SHALL be an input of width OW: the DUT's floor(log2(stim)) result.
REQ-009: Port dut_zero SHALL be an input of width 1: the DUT flag indicating stim==0.
REQ-010: Port busy SHALL be an output of width 1: high while in RUN or DRAIN.
REQ-011: Port done SHALL be an output of width 1: a one-cycle pulse at sweep end.
REQ-012: Port pass_cnt SHALL be an output of width WIDTH+1: the number of matching compares.
REQ-013: Port fail_cnt SHALL be an output of width WIDTH+1: the number of mismatching compares.
REQ-014: Port alarm SHALL be an output of width 1: sticky flag, set on the first mismatch.
REQ-015: Port first_fail_stim SHALL be an output of width WIDTH: the stimulus of the first mismatch.

Function
REQ-016: The FSM SHALL have states IDLE, RUN, DRAIN and DONE.
REQ-017: In IDLE, start=1 SHALL cause a transition to RUN at the next edge, and the same edge SHALL clear pass_cnt, fail_cnt, alarm and first_fail_stim.
REQ-018: In RUN, stim SHALL take 0, 1, ..., 2^WIDTH-1 on consecutive cycles, one value per cycle, starting with 0 in the first RUN cycle.
REQ-019: After stim = 2^WIDTH-1, the FSM SHALL enter DRAIN for exactly LAT cycles (skipped when LAT=0), then DONE for one cycle, then IDLE.
REQ-020: stim SHALL hold its last value in DRAIN, DONE and IDLE, and SHALL be 0 after reset.
REQ-021: The expected value for each issued stim SHALL be computed internally: exp_zero=1 when stim==0; otherwise exp_zero=0 and exp_val = index of the most significant 1 bit.
REQ-022: The (exp_zero, exp_val, stim, valid) tuple SHALL pass through a LAT-stage delay line; with LAT=0 the comparison SHALL occur in the same cycle the stim is driven.
REQ-023: On a delayed valid with exp_zero=1, the result SHALL be a match iff dut_zero==1; dut_out SHALL be ignored.
REQ-024: On a delayed valid with exp_zero=0, the result SHALL be a match iff dut_zero==0 and dut_out==exp_val.
REQ-025: Any X/Z value on dut_out or dut_zero SHALL count as a mismatch (4-state compare in simulation; the RTL compares via a known-value check).
REQ-026: A match SHALL increment pass_cnt by 1; a mismatch SHALL increment fail_cnt by 1; exactly one of the two SHALL increment per valid compare.
REQ-027: On the first mismatch of a sweep, alarm SHALL go to 1 and first_fail_stim SHALL capture the delayed stim; later mismatches SHALL NOT change first_fail_stim.
REQ-028: alarm SHALL remain 1 until the next accepted start or rst.
REQ-029: At done, pass_cnt + fail_cnt SHALL equal 2^WIDTH; counters SHALL never wrap.
REQ-030: done SHALL be 1 only in the DONE state; busy SHALL be 0 in DONE and IDLE.
REQ-031: start SHALL be ignored in RUN, DRAIN and DONE, with no effect on the sweep or counters.
REQ-032: Results (pass_cnt, fail_cnt, alarm, first_fail_stim) SHALL hold in IDLE until the next accepted start.
REQ-033: Timing: if start is sampled at edge 0, stim=k SHALL be present during cycle k+1, and done SHALL be high during cycle 2^WIDTH+LAT+1.

Reset
REQ-034: rst=1 at any edge, including mid-RUN or mid-DRAIN, SHALL force state IDLE and clear stim, busy, done, pass_cnt, fail_cnt, alarm, first_fail_stim and all delay-line valid bits to 0.
REQ-035: rst SHALL take priority over start in the same cycle.
REQ-036: A start after reset SHALL yield a full, clean sweep, with no residue from the aborted sweep.

Verification
REQ-037: Scenario: WIDTH=10, LAT=1, ideal DUT model (registered encoder, zero flag at 0), start pulse -> done pulse 1026 cycles after start, pass_cnt=1024, fail_cnt=0, alarm=0.
REQ-038: Scenario: DUT model that outputs 4'hF whenever stim[3:0]==4'b1011 (trigger) -> fail_cnt=64, pass_cnt=960, alarm=1, first_fail_stim=11.
REQ-039: Scenario: DUT drives dut_zero=0 and dut_out=0 for stim 0 -> fail_cnt=1, first_fail_stim=0, alarm=1.
REQ-040: Scenario: assert rst while stim=500 -> next cycle all outputs 0 and busy=0; a new start then gives pass_cnt=1024, fail_cnt=0.
REQ-041: Scenario: start pulses at stim=100 and in the DONE cycle -> ignored, with exactly one done per accepted start and unchanged final counts.
REQ-042: Scenario: LAT=0 with a combinational ideal DUT, and LAT=3 with a 3-stage ideal DUT -> pass_cnt=1024 in each case, with done 1025 and 1028 cycles after start respectively.
